// File: rtl/VX_rop_pkg.sv
// Shared ROP types and default timing for the blend datapath and its arbiter.
package VX_rop_pkg;

  localparam int unsigned ROP_BLEND_LATENCY   = 3;
  localparam int unsigned ROP_BLEND_ARB_DEPTH = 5;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgba_t;

endpackage

// File: rtl/VX_fifo_queue.sv
// Generic register-based FIFO; head entry is presented directly from storage.
module VX_fifo_queue #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTRW-1:0]  rd_ptr;
  logic [PTRW-1:0]  wr_ptr;
  logic [CNTW-1:0]  count;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Storage write; occupancy is bounded by the caller so no full check.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign data_out = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/rop_blend_arb.sv
// Round-robin, credit-protected sharing of one fixed-latency blend pipe
// between NUM_REQS requesters, with index tracking and a response FIFO.
module rop_blend_arb
  import VX_rop_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned LATENCY  = ROP_BLEND_LATENCY,
  parameter int unsigned DEPTH    = ROP_BLEND_ARB_DEPTH,
  localparam int unsigned IDXW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQS-1:0]    req_valid,
  input  logic [NUM_REQS*32-1:0] req_src,
  input  logic [NUM_REQS*32-1:0] req_dst,
  output logic [NUM_REQS-1:0]    req_ready,
  output logic                   blend_valid,
  output logic [31:0]            blend_src,
  output logic [31:0]            blend_dst,
  input  logic                   blend_result_valid,
  input  logic [31:0]            blend_result,
  output logic                   rsp_valid,
  output logic [IDXW-1:0]        rsp_idx,
  output logic [31:0]            rsp_color,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned CNTW  = $clog2(DEPTH + 1);
  localparam int unsigned DATAW = IDXW + 32;

  rgba_t [NUM_REQS-1:0] src_arr;
  rgba_t [NUM_REQS-1:0] dst_arr;

  logic [CNTW-1:0]             cnt;
  logic [IDXW-1:0]             ptr;
  logic [IDXW-1:0]             grant_idx;
  logic [IDXW-1:0]             cand;
  logic                        grant_found;
  logic                        credit_ok;
  logic                        issue;
  logic                        rsp_fire;
  logic                        fifo_empty;
  logic [DATAW-1:0]            fifo_out;
  logic [LATENCY-1:0]          tag_valid;
  logic [LATENCY-1:0][IDXW-1:0] tag_idx;

  assign src_arr = req_src;
  assign dst_arr = req_dst;

  // Scan from ptr+1 with wrap and pick the first valid requester.
  always_comb begin
    grant_idx   = ptr;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQS; k++) begin
      cand = IDXW'((32'(ptr) + k) % NUM_REQS);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Issue gating by available credit, and the granted operand mux.
  always_comb begin
    credit_ok   = (cnt < CNTW'(DEPTH));
    issue       = credit_ok & (|req_valid);
    blend_valid = issue;
    req_ready   = '0;
    if (credit_ok && grant_found) begin
      req_ready = NUM_REQS'(1) << grant_idx;
    end
    blend_src = src_arr[grant_idx];
    blend_dst = dst_arr[grant_idx];
  end

  assign rsp_fire = rsp_valid & rsp_ready;

  // Credits cover every request from issue until its response is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({issue, rsp_fire})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Round-robin pointer remembers the last granted requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IDXW'(NUM_REQS - 1);
    end else if (issue) begin
      ptr <= grant_idx;
    end
  end

  // Tag pipe mirrors the blend pipe so each result knows its owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_idx   <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_idx[0]   <= grant_idx;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
    end
  end

  // Sticky flag for a result strobe that disagrees with the tracked tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (blend_result_valid != tag_valid[LATENCY-1]) begin
      err <= 1'b1;
    end
  end

  VX_fifo_queue #(
    .DATAW (DATAW),
    .DEPTH (DEPTH)
  ) rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (blend_result_valid),
    .pop      (rsp_fire),
    .data_in  ({tag_idx[LATENCY-1], blend_result}),
    .data_out (fifo_out),
    .empty    (fifo_empty)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_idx   = fifo_out[DATAW-1:32];
  assign rsp_color = fifo_out[31:0];
  assign busy      = (cnt != '0);

endmodule

// File: tb/tb_rop_blend_arb.sv
// Scoreboard bench for rop_blend_arb with a behavioural 3-cycle XOR blend pipe.
module tb_rop_blend_arb;
  import VX_rop_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned LAT  = 3;
  localparam int unsigned DEP  = 5;
  localparam int unsigned IDXW = 2;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [31:0]     color;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*32-1:0]   req_src;
  logic [N*32-1:0]   req_dst;
  logic [N-1:0]      req_ready;
  logic              blend_valid;
  logic [31:0]       blend_src;
  logic [31:0]       blend_dst;
  logic              blend_result_valid;
  logic [31:0]       blend_result;
  logic              rsp_valid;
  logic [IDXW-1:0]   rsp_idx;
  logic [31:0]       rsp_color;
  logic              rsp_ready;
  logic              busy;
  logic              err;

  logic [N-1:0][31:0] src_a;
  logic [N-1:0][31:0] dst_a;
  logic               inject;
  logic [LAT-1:0]     pv;
  logic [31:0]        pd [LAT];

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Hand-computed results: src ^ dst per requester.
  logic [31:0] src_tab [N] = '{32'h11000000, 32'h22000000, 32'h33000000, 32'h44000000};
  logic [31:0] dst_tab [N] = '{32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044};
  logic [31:0] exp_tab [N] = '{32'h11000011, 32'h22000022, 32'h33000033, 32'h44000044};

  assign req_src = src_a;
  assign req_dst = dst_a;

  rop_blend_arb #(.NUM_REQS(N), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_src            (req_src),
    .req_dst            (req_dst),
    .req_ready          (req_ready),
    .blend_valid        (blend_valid),
    .blend_src          (blend_src),
    .blend_dst          (blend_dst),
    .blend_result_valid (blend_result_valid),
    .blend_result       (blend_result),
    .rsp_valid          (rsp_valid),
    .rsp_idx            (rsp_idx),
    .rsp_color          (rsp_color),
    .rsp_ready          (rsp_ready),
    .busy               (busy),
    .err                (err)
  );

  always #5 clk = ~clk;

  // Blend pipe stand-in: fixed latency, result = src ^ dst.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], blend_valid};
      pd[0] <= blend_src ^ blend_dst;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end

  assign blend_result_valid = pv[LAT-1] | inject;
  assign blend_result       = pd[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [31:0] color);
    exp_t e;
    e.idx   = IDXW'(idx);
    e.color = color;
    return e;
  endfunction

  // Response monitor: every accepted response must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got idx %0d color %h expected none", rsp_idx, rsp_color);
      end else begin
        e = sb.pop_front();
        check("rsp_idx", 32'(rsp_idx), 32'(e.idx));
        check("rsp_color", rsp_color, e.color);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    inject    = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int c;
    c         = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || busy) && c < max_cyc) begin
      step();
      c++;
    end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, busy %0b expected 0 pending, busy 0", sb.size(), busy);
    end
    check("err_clean", 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    inject    = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_a[i] = src_tab[i];
      dst_a[i] = dst_tab[i];
    end

    // Reset state
    @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_blend_valid_idle", 32'(blend_valid), 32'd0);
    check("rst_req_ready_idle", 32'(req_ready), 32'd0);
    req_valid = 4'b0100;
    #1;
    check("rst_blend_valid_req", 32'(blend_valid), 32'd1);
    check("rst_req_ready_req", 32'(req_ready), 32'h4);
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single request latency
    step();
    src_a[0]  = 32'h80402010;
    dst_a[0]  = 32'h01020304;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    sb.push_back(mk(0, 32'h81422314));
    @(negedge clk);
    check("single_blend_valid", 32'(blend_valid), 32'd1);
    check("single_req_ready", 32'(req_ready), 32'h1);
    check("single_blend_src", blend_src, 32'h80402010);
    check("single_blend_dst", blend_dst, 32'h01020304);
    for (int c = 1; c <= 3; c++) begin
      step();
      req_valid = '0;
      @(negedge clk);
      check("single_rsp_early", 32'(rsp_valid), 32'd0);
    end
    step();
    @(negedge clk);
    check("single_rsp_cycle4", 32'(rsp_valid), 32'd1);
    step();
    @(negedge clk);
    check("single_rsp_done", 32'(rsp_valid), 32'd0);
    check("single_busy_done", 32'(busy), 32'd0);
    src_a[0] = src_tab[0];
    dst_a[0] = dst_tab[0];

    // Round-robin fairness at full throughput
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      req_valid = '1;
      sb.push_back(mk(k % 4, exp_tab[k % 4]));
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(N'(1) << (k % 4)));
      check("rr_issue", 32'(blend_valid), 32'd1);
    end
    step();
    drain(40);

    // Credit stall with rsp_ready low
    do_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      req_valid = '1;
      sb.push_back(mk(k % 4, exp_tab[k % 4]));
      @(negedge clk);
      check("stall_grant", 32'(req_ready), 32'(N'(1) << (k % 4)));
    end
    for (int k = 5; k < 9; k++) begin
      step();
      @(negedge clk);
      check("stall_blend_valid", 32'(blend_valid), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_pop_cycle_no_issue", 32'(blend_valid), 32'd0);
    step();
    rsp_ready = 1'b0;
    sb.push_back(mk(1, exp_tab[1]));
    @(negedge clk);
    check("stall_resume_grant", 32'(req_ready), 32'h2);
    check("stall_resume_issue", 32'(blend_valid), 32'd1);
    step();
    @(negedge clk);
    check("stall_refull", 32'(blend_valid), 32'd0);
    step();
    drain(40);

    // Simultaneous issue and pop at cnt = DEPTH-1
    do_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      req_valid = '1;
      sb.push_back(mk(k, exp_tab[k]));
    end
    step();
    req_valid = '0;
    step();
    req_valid = '1;
    rsp_ready = 1'b1;
    sb.push_back(mk(0, exp_tab[0]));
    @(negedge clk);
    check("sim_issue_pop_grant", 32'(req_ready), 32'h1);
    step();
    rsp_ready = 1'b0;
    sb.push_back(mk(1, exp_tab[1]));
    @(negedge clk);
    check("sim_after_cnt_held", 32'(blend_valid), 32'd1);
    check("sim_after_grant", 32'(req_ready), 32'h2);
    step();
    @(negedge clk);
    check("sim_now_full", 32'(blend_valid), 32'd0);
    step();
    drain(40);

    // Protocol error: result strobe without a matching issue
    rsp_ready = 1'b0;
    step();
    inject = 1'b1;
    @(negedge clk);
    check("err_before", 32'(err), 32'd0);
    step();
    inject = 1'b0;
    @(negedge clk);
    check("err_set", 32'(err), 32'd1);
    check("err_data_written", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
    end

    // Reset mid-operation: 3 in flight, 2 buffered
    do_reset();
    check("err_cleared_by_reset", 32'(err), 32'd0);
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      req_valid = '1;
      sb.push_back(mk(k % 4, exp_tab[k % 4]));
    end
    step();
    @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    check("mid_rsp_before", 32'(rsp_valid), 32'd1);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_priority", 32'(req_ready), 32'h1);
    check("mid_blend_valid", 32'(blend_valid), 32'd1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    sb.push_back(mk(0, exp_tab[0]));
    @(negedge clk);
    check("post_reset_grant", 32'(req_ready), 32'h1);
    step();
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
